threeway_enc_ctrl: RTL and testbench
====================================

Name: threeway_enc_ctrl

Overview:
Iterative 3-Way (96-bit block, 96-bit key) encryption controller: one round per clock, with a valid/ready handshake on input and output.
- Owns the round counter, the round-constant LFSR and the FSM.
- Time-shares a single instance of the existing theta block `linear` (iword/oword, 96-bit, word0 = bits [31:0]) between the 11 round computations and the final output transform.
- Sits between the host-side block FIFO and the ciphertext sink.

Parameters:
- ROUNDS, 11, number of full rho rounds before the final theta. Values below 11 are for reduced-round debug only.
- RC_INIT, 16'h0b0b, first encryption round constant.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block/key valid.
- in_ready  out  1  controller can accept a block (high only in IDLE).
- in_data  in  96  plaintext; a0=[31:0], a1=[63:32], a2=[95:64].
- in_key  in  96  key, same word order.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  sink accepts ciphertext.
- out_data  out  96  ciphertext, same word order.
- busy  out  1  high in RUN or FINAL.

Behaviour:
- Reset: state=IDLE, round counter=0, rc=RC_INIT, state/key registers=0, out_data=0, out_valid=0, busy=0.
- in_ready is a decode of IDLE, so it reads 1 while reset is held.
- Reset is asynchronous and aborts any block in flight. No partial result is ever presented.
- Keymix km(s, rc): a0 ^= k0 ^ {rc,16'h0}; a1 ^= k1; a2 ^= k2 ^ {16'h0,rc}.
- `linear` input is always km(state_reg, rc_reg).
- Round path: pi_2(gamma(pi_1(lin_out))).
  - pi_1: a0 rotr 10, a2 rotl 1.
  - gamma: a0' = a0^(a1|~a2), a1' = a1^(a2|~a0), a2' = a2^(a0|~a1).
  - pi_2: a0 rotl 1, a2 rotr 10.
- rc update: rc_next = (rc<<1) with bit16 folded, i.e. if bit16 set, XOR 17'h11011; keep 16 bits.
  - Sequence: 0b0b, 1616, 2c2c, 5858, b0b0, 7171, e2e2, d5d5, bbbb, 6767, cece, 8d8d.
- FSM:
  - IDLE: when in_valid && in_ready, at that edge capture in_data->state_reg and in_key->key_reg, set rc=RC_INIT, cnt=0, go to RUN. in_key/in_data are not sampled afterwards.
  - RUN: each edge, state_reg <= round path, rc <= rc_next, cnt++. After the edge with cnt==ROUNDS-1, go to FINAL.
  - FINAL: one edge, state_reg <= lin_out (theta only, using the ROUNDS-th constant, 8d8d for ROUNDS=11); out_valid <= 1; go to DONE.
  - DONE: out_data = state_reg, held stable while out_valid && !out_ready. On out_ready, out_valid <= 0 and go to IDLE.
- Latency:
  - Accepting edge A, rounds on edges A+1..A+11, out_valid high after edge A+12.
  - Minimum block period is 14 cycles (out handshake at A+13, next accept at A+14).
- in_valid while not IDLE is ignored; no error flag is raised. out_ready while out_valid=0 is ignored.
- Widths: all word arithmetic is 32-bit with wrap-free XOR/rotate. The counter is $clog2(ROUNDS) bits minimum.

Decomposition:
- Package threeway_pkg holds:
  - WORD_W=32, BLOCK_W=96, RC_POLY=17'h11011.
  - typedef state_t (IDLE, RUN, FINAL, DONE).
  - typedef block_t (3x32 packed).
  - functions pi1, pi2, gamma, keymix, rc_next.
- Sub-module: only the existing `linear`, instantiated once. No new sub-module.

Test Plan:
- Reset with no stimulus -> in_ready=1, out_valid=0, busy=0, out_data=96'h0.
- Known-answer: key=0, in_data words a0=a1=a2=32'h1 -> out_valid exactly 12 cycles after the accepting edge. out_data equals the C golden model (model print: ad21ecf7 83ae9dc4 4059c76e); rc observed 0b0b..8d8d in order.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and out_data stable, in_ready=0. Then out_ready=1 -> in_ready=1 the following cycle.
- Input isolation: toggle in_data/in_key and hold in_valid=1 during RUN -> result unchanged; a second block is accepted only after DONE->IDLE.
- Abort: drop rst_n during round 5 -> out_valid=0, busy=0 immediately; a fresh block afterwards produces the correct golden result.
- Regression: 100 C-model vectors with out_ready=1 and in_valid=1 back-to-back -> all match, one block every 14 cycles.

Source files
------------

// File: rtl/threeway_pkg.sv
// Shared types, constants and round helpers for the 3-Way encryption core.
// Block word order everywhere: a0 = [31:0], a1 = [63:32], a2 = [95:64].
package threeway_pkg;

    localparam int          WORD_W  = 32;
    localparam int          BLOCK_W = 96;
    localparam logic [16:0] RC_POLY = 17'h11011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINAL,
        DONE
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] a2;
        logic [WORD_W-1:0] a1;
        logic [WORD_W-1:0] a0;
    } block_t;

    function automatic block_t pi1(input block_t s);
        block_t r;
        r    = s;
        r.a0 = {s.a0[9:0], s.a0[31:10]};
        r.a2 = {s.a2[30:0], s.a2[31]};
        return r;
    endfunction

    function automatic block_t pi2(input block_t s);
        block_t r;
        r    = s;
        r.a0 = {s.a0[30:0], s.a0[31]};
        r.a2 = {s.a2[9:0], s.a2[31:10]};
        return r;
    endfunction

    function automatic block_t gamma(input block_t s);
        block_t r;
        r.a0 = s.a0 ^ (s.a1 | ~s.a2);
        r.a1 = s.a1 ^ (s.a2 | ~s.a0);
        r.a2 = s.a2 ^ (s.a0 | ~s.a1);
        return r;
    endfunction

    function automatic block_t keymix(
        input block_t      s,
        input block_t      k,
        input logic [15:0] rc
    );
        block_t r;
        r.a0 = s.a0 ^ k.a0 ^ {rc, 16'h0};
        r.a1 = s.a1 ^ k.a1;
        r.a2 = s.a2 ^ k.a2 ^ {16'h0, rc};
        return r;
    endfunction

    // Shift left in GF(2); a carry into bit 16 folds back via the polynomial.
    function automatic logic [15:0] rc_next(input logic [15:0] rc);
        logic [16:0] t;
        t = {rc, 1'b0};
        if (t[16]) begin
            t = t ^ RC_POLY;
        end
        return t[15:0];
    endfunction

endpackage

// File: rtl/linear.sv
// Theta linear mixing layer of 3-Way (combinational, 96-bit).
// Ports: iword (96-bit block in), oword (96-bit block out), word0 = [31:0].
module linear (
    input  logic [95:0] iword,
    output logic [95:0] oword
);

    // Output word for position i given words i, i+1, i+2 (mod 3).
    function automatic logic [31:0] th(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z
    );
        return x ^ (x >> 16) ^ (y << 16) ^ (y >> 16) ^ (z << 16)
                 ^ (y >> 24) ^ (z << 8)  ^ (z >> 8)  ^ (x << 24)
                 ^ (z >> 16) ^ (x << 16) ^ (z >> 24) ^ (x << 8);
    endfunction

    logic [31:0] w0, w1, w2;

    assign w0 = iword[31:0];
    assign w1 = iword[63:32];
    assign w2 = iword[95:64];

    assign oword = {th(w2, w0, w1), th(w1, w2, w0), th(w0, w1, w2)};

endmodule

// File: rtl/threeway_enc_ctrl.sv
// Iterative 3-Way encryption controller: one rho round per clock, one shared
// theta instance, valid/ready on both sides.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_data/in_key
// (block intake, accepted only in IDLE); out_valid/out_ready/out_data
// (ciphertext, held until taken); busy (RUN or FINAL).
module threeway_enc_ctrl
    import threeway_pkg::*;
#(
    parameter int          ROUNDS  = 11,
    parameter logic [15:0] RC_INIT = 16'h0b0b
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] in_data,
    input  logic [95:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_data,
    output logic        busy
);

    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      rc_q;
    block_t           blk_q;
    block_t           key_q;
    logic             out_valid_q;

    block_t lin_in;
    block_t lin_out;
    block_t round_out;

    // Theta always sees the key-mixed state; RUN and FINAL differ only in
    // whether the nonlinear part follows it.
    assign lin_in = keymix(blk_q, key_q, rc_q);

    linear u_linear (
        .iword(lin_in),
        .oword(lin_out)
    );

    assign round_out = pi2(gamma(pi1(lin_out)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rc_q        <= RC_INIT;
            blk_q       <= '0;
            key_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        blk_q   <= block_t'(in_data);
                        key_q   <= block_t'(in_key);
                        rc_q    <= RC_INIT;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    blk_q <= round_out;
                    rc_q  <= rc_next(rc_q);
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    blk_q       <= lin_out;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN) || (state_q == FINAL);
    assign out_valid = out_valid_q;
    // Intermediate round states never leak onto the output bus.
    assign out_data  = out_valid_q ? 96'(blk_q) : '0;

endmodule

// File: tb/tb_threeway_enc_ctrl.sv
// Self-checking bench for threeway_enc_ctrl: directed steps plus random
// vectors compared against a whole-block 3-Way reference model.
module tb_threeway_enc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [95:0] in_data = '0;
    logic [95:0] in_key = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [95:0] out_data;

    int checks = 0;
    int errors = 0;

    localparam logic [95:0] KAT_PT = {32'h1, 32'h1, 32'h1};
    localparam logic [95:0] KAT_CT = 96'had21ecf7_83ae9dc4_4059c76e;

    logic [15:0] rc_seq [12] = '{
        16'h0b0b, 16'h1616, 16'h2c2c, 16'h5858, 16'hb0b0, 16'h7171,
        16'he2e2, 16'hd5d5, 16'hbbbb, 16'h6767, 16'hcece, 16'h8d8d
    };

    always #5 clk = ~clk;

    threeway_enc_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_key   (in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    function automatic logic [95:0] model_enc(
        input logic [95:0] pt,
        input logic [95:0] key,
        input int          nr
    );
        logic [31:0] a [3];
        logic [31:0] k [3];
        logic [31:0] b [3];
        logic [31:0] x, y, z;
        int unsigned rc;
        for (int i = 0; i < 3; i++) begin
            a[i] = pt[32*i +: 32];
            k[i] = key[32*i +: 32];
        end
        rc = 32'h0b0b;
        for (int r = 0; r <= nr; r++) begin
            for (int i = 0; i < 3; i++) a[i] = a[i] ^ k[i];
            a[0] = a[0] ^ (rc << 16);
            a[2] = a[2] ^ rc;
            for (int i = 0; i < 3; i++) begin
                x = a[i];
                y = a[(i + 1) % 3];
                z = a[(i + 2) % 3];
                b[i] = x ^ (x >> 16) ^ (y << 16) ^ (y >> 16) ^ (z << 16)
                     ^ (y >> 24) ^ (z << 8) ^ (z >> 8) ^ (x << 24)
                     ^ (z >> 16) ^ (x << 16) ^ (z >> 24) ^ (x << 8);
            end
            a = b;
            if (r < nr) begin
                a[0] = (a[0] >> 10) | (a[0] << 22);
                a[2] = (a[2] << 1) | (a[2] >> 31);
                b[0] = a[0] ^ (a[1] | ~a[2]);
                b[1] = a[1] ^ (a[2] | ~a[0]);
                b[2] = a[2] ^ (a[0] | ~a[1]);
                a = b;
                a[0] = (a[0] << 1) | (a[0] >> 31);
                a[2] = (a[2] >> 10) | (a[2] << 22);
            end
            rc = rc << 1;
            if ((rc & 32'h10000) != 0) rc = rc ^ 32'h11011;
        end
        return {a[2], a[1], a[0]};
    endfunction

    task automatic chk(
        input string       tag,
        input logic [95:0] obs,
        input logic [95:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic [95:0] held, pt, k, pt2, k2;
        logic [95:0] vp [100];
        logic [95:0] vk [100];
        logic [95:0] exp_q [$];
        int          nxt, got, cyc, last_acc, bad_period;

        // Reset held, no stimulus
        #2;
        chk("rst_in_ready", 96'(in_ready), 96'd1);
        chk("rst_out_valid", 96'(out_valid), 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_out_data", out_data, 96'h0);
        #10 rst_n = 1'b1;
        step();

        // Known answer with round-constant trace
        in_data  = KAT_PT;
        in_key   = '0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("kat_busy", 96'(busy), 96'd1);
        chk("kat_in_ready", 96'(in_ready), 96'd0);
        chk("kat_rc0", 96'(dut.rc_q), 96'(rc_seq[0]));
        for (int r = 1; r < 12; r++) begin
            step();
            chk($sformatf("kat_rc%0d", r), 96'(dut.rc_q), 96'(rc_seq[r]));
            chk("kat_no_early_valid", 96'(out_valid), 96'd0);
        end
        step();
        chk("kat_latency12", 96'(out_valid), 96'd1);
        chk("kat_golden", out_data, KAT_CT);
        chk("kat_model", out_data, model_enc(KAT_PT, '0, 11));
        chk("kat_done_busy", 96'(busy), 96'd0);

        // Backpressure
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 96'(out_valid), 96'd1);
            chk("bp_data", out_data, held);
            chk("bp_in_ready", 96'(in_ready), 96'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_ready", 96'(in_ready), 96'd1);
        chk("bp_release_valid", 96'(out_valid), 96'd0);

        // Input isolation while busy
        pt = rnd96();
        k  = rnd96();
        in_data  = pt;
        in_key   = k;
        in_valid = 1'b1;
        step();
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            in_data = rnd96();
            in_key  = rnd96();
            step();
            lat++;
        end
        chk("iso_latency", 96'(lat), 96'd12);
        chk("iso_result", out_data, model_enc(pt, k, 11));
        pt2 = rnd96();
        k2  = rnd96();
        in_data   = pt2;
        in_key    = k2;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("iso_not_taken_in_done", 96'(busy), 96'd0);
        chk("iso_idle_ready", 96'(in_ready), 96'd1);
        step();
        in_valid = 1'b0;
        chk("iso_second_accept", 96'(busy), 96'd1);
        wait_out(lat);
        chk("iso2_latency", 96'(lat), 96'd12);
        chk("iso2_result", out_data, model_enc(pt2, k2, 11));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Abort during round 5
        in_data  = rnd96();
        in_key   = rnd96();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("abort_pre_busy", 96'(busy), 96'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 96'(out_valid), 96'd0);
        chk("abort_busy", 96'(busy), 96'd0);
        chk("abort_ready", 96'(in_ready), 96'd1);
        chk("abort_data", out_data, 96'h0);
        #2 rst_n = 1'b1;
        step();
        chk("abort_no_partial", 96'(out_valid), 96'd0);
        in_data  = KAT_PT;
        in_key   = '0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        chk("abort_fresh_latency", 96'(lat), 96'd12);
        chk("abort_fresh_golden", out_data, KAT_CT);
        out_ready = 1'b1;
        step();

        // Back-to-back random regression
        for (int i = 0; i < 100; i++) begin
            vp[i] = rnd96();
            vk[i] = rnd96();
        end
        nxt = 0;
        got = 0;
        cyc = 0;
        last_acc = -1;
        bad_period = 0;
        in_data  = vp[0];
        in_key   = vk[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (got < 100 && cyc < 1500) begin
            if (in_ready === 1'b1 && nxt < 100) begin
                exp_q.push_back(model_enc(vp[nxt], vk[nxt], 11));
                if (last_acc >= 0 && cyc - last_acc != 14) bad_period++;
                last_acc = cyc;
                nxt++;
            end
            step();
            cyc++;
            if (nxt < 100) begin
                in_data = vp[nxt];
                in_key  = vk[nxt];
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                if (exp_q.size() > 0) begin
                    chk($sformatf("regr_%0d", got), out_data, exp_q.pop_front());
                end else begin
                    chk("regr_spurious_valid", 96'(out_valid), 96'd0);
                end
                got++;
            end
        end
        chk("regr_count", 96'(got), 96'd100);
        chk("regr_period14", 96'(bad_period), 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
